// File: rtl/st7789_spi_sink_pkg.sv
// Shared opcodes, panel geometry and decoder state encoding for the ST7789 SPI sink.
package st7789_spi_sink_pkg;

  localparam logic [7:0] ST7789_CASET = 8'h2A;
  localparam logic [7:0] ST7789_RASET = 8'h2B;
  localparam logic [7:0] ST7789_RAMWR = 8'h2C;

  localparam int LCD_W = 240;
  localparam int LCD_H = 240;

  localparam logic [7:0] XE_RESET = 8'(LCD_W - 1);
  localparam logic [7:0] YE_RESET = 8'(LCD_H - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CASET0, ST_CASET1, ST_CASET2, ST_CASET3,
    ST_RASET0, ST_RASET1, ST_RASET2, ST_RASET3,
    ST_RAMWR_HI, ST_RAMWR_LO
  } state_t;

  // Where a command byte sends the decoder, regardless of the current state.
  function automatic state_t cmd_next_state(input logic [7:0] op);
    case (op)
      ST7789_CASET: return ST_CASET0;
      ST7789_RASET: return ST_RASET0;
      ST7789_RAMWR: return ST_RAMWR_HI;
      default:      return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/st7789_spi_byte_rx.sv
// Synchronizes the SPI pins, detects SCL rising edges and assembles {dc, byte} frames,
// dropping a partial byte when SCL idles high for too long.
module st7789_spi_byte_rx #(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl,
  input  logic       sda,
  input  logic       dc_raw,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       dc
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync, dc_sync;
  logic                   scl_d;
  logic [6:0]             shreg;
  logic [2:0]             bitcnt;
  logic [IW-1:0]          idle_cnt;
  logic                   scl_s, sda_s, dc_s, rise;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign dc_s  = dc_sync[SYNC_STAGES-1];
  assign rise  = scl_s & ~scl_d;

  // SCL resets to its idle-high level so releasing reset never looks like a rising edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync   <= '1;
      sda_sync   <= '0;
      dc_sync    <= '0;
      scl_d      <= 1'b1;
      shreg      <= '0;
      bitcnt     <= '0;
      idle_cnt   <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      dc         <= 1'b0;
    end else begin
      scl_sync   <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync   <= {sda_sync[SYNC_STAGES-2:0], sda};
      dc_sync    <= {dc_sync[SYNC_STAGES-2:0], dc_raw};
      scl_d      <= scl_s;
      byte_valid <= 1'b0;
      if (rise) begin
        shreg    <= {shreg[5:0], sda_s};
        idle_cnt <= '0;
        if (bitcnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shreg, sda_s};
          dc         <= dc_s;
          bitcnt     <= '0;
        end else begin
          bitcnt <= bitcnt + 3'd1;
        end
      end else if (scl_s && bitcnt != 3'd0) begin
        if (idle_cnt == IW'(IDLE_TIMEOUT - 1)) begin
          bitcnt   <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + IW'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/st7789_spi_sink.sv
// ST7789 command decoder: tracks the CASET/RASET window and turns RAMWR data into
// framebuffer pixel writes addressed {y, x}.
module st7789_spi_sink
  import st7789_spi_sink_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        st7789_SDA,
  input  logic        st7789_SCL,
  input  logic        st7789_DC,
  output logic        cmd_valid_o,
  output logic [7:0]  cmd_o,
  output logic        pix_we_o,
  output logic [15:0] pix_addr_o,
  output logic [15:0] pix_data_o,
  output logic        frame_done_o
);

  logic       byte_valid, rx_dc;
  logic [7:0] rx_byte;

  st7789_spi_byte_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_byte_rx (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .scl       (st7789_SCL),
    .sda       (st7789_SDA),
    .dc_raw    (st7789_DC),
    .byte_valid(byte_valid),
    .byte_data (rx_byte),
    .dc        (rx_dc)
  );

  state_t      state, state_n;
  logic [7:0]  xs, xe, ys, ye, x, y, hi;
  logic [7:0]  xs_n, xe_n, ys_n, ye_n, x_n, y_n, hi_n;
  logic        cmd_valid_n, pix_we_n, frame_done_n;
  logic [7:0]  cmd_n;
  logic [15:0] pix_addr_n, pix_data_n;

  always_comb begin
    state_n      = state;
    xs_n         = xs;
    xe_n         = xe;
    ys_n         = ys;
    ye_n         = ye;
    x_n          = x;
    y_n          = y;
    hi_n         = hi;
    cmd_valid_n  = 1'b0;
    cmd_n        = cmd_o;
    pix_we_n     = 1'b0;
    pix_addr_n   = pix_addr_o;
    pix_data_n   = pix_data_o;
    frame_done_n = 1'b0;
    if (byte_valid) begin
      if (!rx_dc) begin
        cmd_valid_n = 1'b1;
        cmd_n       = rx_byte;
        state_n     = cmd_next_state(rx_byte);
        if (rx_byte == ST7789_RAMWR) begin
          x_n = xs;
          y_n = ys;
        end
      end else begin
        // High parameter bytes (p0, p2) only advance the state; coordinates are 8-bit.
        case (state)
          ST_CASET0:   state_n = ST_CASET1;
          ST_CASET1:   begin xs_n = rx_byte; state_n = ST_CASET2; end
          ST_CASET2:   state_n = ST_CASET3;
          ST_CASET3:   begin xe_n = rx_byte; state_n = ST_IDLE; end
          ST_RASET0:   state_n = ST_RASET1;
          ST_RASET1:   begin ys_n = rx_byte; state_n = ST_RASET2; end
          ST_RASET2:   state_n = ST_RASET3;
          ST_RASET3:   begin ye_n = rx_byte; state_n = ST_IDLE; end
          ST_RAMWR_HI: begin hi_n = rx_byte; state_n = ST_RAMWR_LO; end
          ST_RAMWR_LO: begin
            pix_we_n   = 1'b1;
            pix_addr_n = {y, x};
            pix_data_n = {hi, rx_byte};
            state_n    = ST_RAMWR_HI;
            if (x == xe) begin
              x_n = xs;
              if (y == ye) begin
                y_n          = ys;
                frame_done_n = 1'b1;
              end else begin
                y_n = y + 8'd1;
              end
            end else begin
              x_n = x + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      xs           <= 8'd0;
      xe           <= XE_RESET;
      ys           <= 8'd0;
      ye           <= YE_RESET;
      x            <= 8'd0;
      y            <= 8'd0;
      hi           <= 8'd0;
      cmd_valid_o  <= 1'b0;
      cmd_o        <= 8'd0;
      pix_we_o     <= 1'b0;
      pix_addr_o   <= 16'd0;
      pix_data_o   <= 16'd0;
      frame_done_o <= 1'b0;
    end else begin
      state        <= state_n;
      xs           <= xs_n;
      xe           <= xe_n;
      ys           <= ys_n;
      ye           <= ye_n;
      x            <= x_n;
      y            <= y_n;
      hi           <= hi_n;
      cmd_valid_o  <= cmd_valid_n;
      cmd_o        <= cmd_n;
      pix_we_o     <= pix_we_n;
      pix_addr_o   <= pix_addr_n;
      pix_data_o   <= pix_data_n;
      frame_done_o <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_st7789_spi_sink.sv
// Directed bench for st7789_spi_sink: byte-level vector table plus hand sequences for
// reset abort, latency, idle timeout and a two-row default-width frame.
module tb_st7789_spi_sink;

  localparam int SYNC_STAGES  = 2;
  localparam int IDLE_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sda = 1'b1;
  logic        scl = 1'b1;
  logic        dc  = 1'b1;
  logic        cmd_valid_o, pix_we_o, frame_done_o;
  logic [7:0]  cmd_o;
  logic [15:0] pix_addr_o, pix_data_o;

  always #5 clk = ~clk;

  st7789_spi_sink #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .st7789_SDA  (sda),
    .st7789_SCL  (scl),
    .st7789_DC   (dc),
    .cmd_valid_o (cmd_valid_o),
    .cmd_o       (cmd_o),
    .pix_we_o    (pix_we_o),
    .pix_addr_o  (pix_addr_o),
    .pix_data_o  (pix_data_o),
    .frame_done_o(frame_done_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Pulse counters and frame-address scoreboard, sampled on the falling edge.
  int          n_cmd = 0, n_pix = 0, n_fd = 0;
  logic [15:0] fd_addr = 16'd0;
  logic        sb_en = 1'b0;
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    if (cmd_valid_o) n_cmd++;
    if (frame_done_o) begin
      n_fd++;
      fd_addr = pix_addr_o;
    end
    if (pix_we_o) begin
      n_pix++;
      if (sb_en) begin
        if (exp_q.size() == 0) chk("frame_addr_unexpected", {16'd0, pix_addr_o}, 32'hFFFF_FFFF);
        else chk("frame_addr", {16'd0, pix_addr_o}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic d, input logic b);
    scl = 1'b0;
    sda = b;
    dc  = d;
    tick(2);
    scl = 1'b1;
    tick(2);
  endtask

  task automatic send_byte(input logic d, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(d, b[i]);
  endtask

  typedef struct {
    logic        dc;
    logic [7:0]  b;
    int          c;
    int          p;
    int          f;
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic d, input logic [7:0] b, input int c, input int p,
                              input int f, input logic [7:0] cmd, input logic [15:0] addr,
                              input logic [15:0] data);
    vec_t v;
    v.dc = d; v.b = b; v.c = c; v.p = p; v.f = f;
    v.cmd = cmd; v.addr = addr; v.data = data;
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, p0, f0, lat;
    logic [15:0] d16;

    // Stimulus table: {dc, byte} -> expected pulse counts and held outputs.
    add(0, 8'h2C, 1, 0, 0, 8'h2C, 16'h0000, 16'h0000);
    add(1, 8'hF8, 0, 0, 0, 8'h2C, 16'h0000, 16'h0000);
    add(1, 8'h00, 0, 1, 0, 8'h2C, 16'h0000, 16'hF800);
    add(0, 8'h2A, 1, 0, 0, 8'h2A, 16'h0000, 16'hF800);
    add(1, 8'h00, 0, 0, 0, 8'h2A, 16'h0000, 16'hF800);
    add(1, 8'h0A, 0, 0, 0, 8'h2A, 16'h0000, 16'hF800);
    add(1, 8'h00, 0, 0, 0, 8'h2A, 16'h0000, 16'hF800);
    add(1, 8'h0B, 0, 0, 0, 8'h2A, 16'h0000, 16'hF800);
    add(0, 8'h2B, 1, 0, 0, 8'h2B, 16'h0000, 16'hF800);
    add(1, 8'h00, 0, 0, 0, 8'h2B, 16'h0000, 16'hF800);
    add(1, 8'h05, 0, 0, 0, 8'h2B, 16'h0000, 16'hF800);
    add(1, 8'h00, 0, 0, 0, 8'h2B, 16'h0000, 16'hF800);
    add(1, 8'h06, 0, 0, 0, 8'h2B, 16'h0000, 16'hF800);
    add(0, 8'h2C, 1, 0, 0, 8'h2C, 16'h0000, 16'hF800);
    add(1, 8'h12, 0, 0, 0, 8'h2C, 16'h0000, 16'hF800);
    add(1, 8'h34, 0, 1, 0, 8'h2C, 16'h050A, 16'h1234);
    add(1, 8'h12, 0, 0, 0, 8'h2C, 16'h050A, 16'h1234);
    add(1, 8'h35, 0, 1, 0, 8'h2C, 16'h050B, 16'h1235);
    add(1, 8'h12, 0, 0, 0, 8'h2C, 16'h050B, 16'h1235);
    add(1, 8'h36, 0, 1, 0, 8'h2C, 16'h060A, 16'h1236);
    add(1, 8'h12, 0, 0, 0, 8'h2C, 16'h060A, 16'h1236);
    add(1, 8'h37, 0, 1, 1, 8'h2C, 16'h060B, 16'h1237);
    add(1, 8'h12, 0, 0, 0, 8'h2C, 16'h060B, 16'h1237);
    add(1, 8'h38, 0, 1, 0, 8'h2C, 16'h050A, 16'h1238);
    // Command abort mid-pixel.
    add(0, 8'h2C, 1, 0, 0, 8'h2C, 16'h050A, 16'h1238);
    add(1, 8'hAB, 0, 0, 0, 8'h2C, 16'h050A, 16'h1238);
    add(0, 8'h00, 1, 0, 0, 8'h00, 16'h050A, 16'h1238);
    add(0, 8'h2C, 1, 0, 0, 8'h2C, 16'h050A, 16'h1238);
    add(1, 8'h00, 0, 0, 0, 8'h2C, 16'h050A, 16'h1238);
    add(1, 8'hFF, 0, 1, 0, 8'h2C, 16'h050A, 16'h00FF);
    // Inverted window XS=0xFE > XE=0x01 on a single row.
    add(0, 8'h2A, 1, 0, 0, 8'h2A, 16'h050A, 16'h00FF);
    add(1, 8'h00, 0, 0, 0, 8'h2A, 16'h050A, 16'h00FF);
    add(1, 8'hFE, 0, 0, 0, 8'h2A, 16'h050A, 16'h00FF);
    add(1, 8'h00, 0, 0, 0, 8'h2A, 16'h050A, 16'h00FF);
    add(1, 8'h01, 0, 0, 0, 8'h2A, 16'h050A, 16'h00FF);
    add(0, 8'h2B, 1, 0, 0, 8'h2B, 16'h050A, 16'h00FF);
    add(1, 8'h00, 0, 0, 0, 8'h2B, 16'h050A, 16'h00FF);
    add(1, 8'h07, 0, 0, 0, 8'h2B, 16'h050A, 16'h00FF);
    add(1, 8'h00, 0, 0, 0, 8'h2B, 16'h050A, 16'h00FF);
    add(1, 8'h07, 0, 0, 0, 8'h2B, 16'h050A, 16'h00FF);
    add(0, 8'h2C, 1, 0, 0, 8'h2C, 16'h050A, 16'h00FF);
    add(1, 8'hA0, 0, 0, 0, 8'h2C, 16'h050A, 16'h00FF);
    add(1, 8'h01, 0, 1, 0, 8'h2C, 16'h07FE, 16'hA001);
    add(1, 8'hA0, 0, 0, 0, 8'h2C, 16'h07FE, 16'hA001);
    add(1, 8'h02, 0, 1, 0, 8'h2C, 16'h07FF, 16'hA002);
    add(1, 8'hA0, 0, 0, 0, 8'h2C, 16'h07FF, 16'hA002);
    add(1, 8'h03, 0, 1, 0, 8'h2C, 16'h0700, 16'hA003);
    add(1, 8'hA0, 0, 0, 0, 8'h2C, 16'h0700, 16'hA003);
    add(1, 8'h04, 0, 1, 1, 8'h2C, 16'h0701, 16'hA004);
    add(1, 8'hA0, 0, 0, 0, 8'h2C, 16'h0701, 16'hA004);
    add(1, 8'h05, 0, 1, 0, 8'h2C, 16'h07FE, 16'hA005);

    // Reset state.
    tick(3);
    chk("rst_cmd_valid", {31'd0, cmd_valid_o}, 32'd0);
    chk("rst_cmd", {24'd0, cmd_o}, 32'd0);
    chk("rst_pix_we", {31'd0, pix_we_o}, 32'd0);
    chk("rst_addr", {16'd0, pix_addr_o}, 32'd0);
    chk("rst_data", {16'd0, pix_data_o}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done_o}, 32'd0);
    rst = 1'b0;
    tick(4);

    // Asynchronous reset in the middle of a byte must discard the partial bits.
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    scl = 1'b0;
    #7 rst = 1'b1;
    #6 rst = 1'b0;
    scl = 1'b1;
    sda = 1'b1;
    tick(6);
    chk("abort_no_cmd", n_cmd, 0);
    chk("abort_no_pix", n_pix, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      c0 = n_cmd; p0 = n_pix; f0 = n_fd;
      send_byte(vecs[i].dc, vecs[i].b);
      tick(4);
      chk($sformatf("v%0d_cmd_pulses", i), n_cmd - c0, vecs[i].c);
      chk($sformatf("v%0d_pix_pulses", i), n_pix - p0, vecs[i].p);
      chk($sformatf("v%0d_frame_pulses", i), n_fd - f0, vecs[i].f);
      chk($sformatf("v%0d_cmd_o", i), {24'd0, cmd_o}, {24'd0, vecs[i].cmd});
      chk($sformatf("v%0d_addr", i), {16'd0, pix_addr_o}, {16'd0, vecs[i].addr});
      chk($sformatf("v%0d_data", i), {16'd0, pix_data_o}, {16'd0, vecs[i].data});
    end

    // Latency: count clk edges from the raw SCL rise of the final lo-byte bit to pix_we_o.
    send_byte(0, 8'h2C);
    send_byte(1, 8'h5A);
    for (int i = 7; i >= 1; i--) send_bit(1, d16_bit(8'hA5, i));
    scl = 1'b0;
    sda = 1'b1;
    tick(2);
    scl = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (pix_we_o) begin
        lat = k;
        break;
      end
    end
    chk("latency_edges", lat, SYNC_STAGES + 2);
    chk("latency_addr", {16'd0, pix_addr_o}, 32'h07FE);
    chk("latency_data", {16'd0, pix_data_o}, 32'h5AA5);
    tick(6);

    // Idle timeout: three stray bits then a long SCL-high idle before a clean command.
    send_byte(0, 8'h00);
    tick(4);
    chk("timeout_pre_cmd", {24'd0, cmd_o}, 32'h00);
    c0 = n_cmd;
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    tick(IDLE_TIMEOUT + 10);
    chk("timeout_no_pulse", n_cmd - c0, 0);
    send_byte(0, 8'h2C);
    tick(4);
    chk("timeout_cmd_pulses", n_cmd - c0, 1);
    chk("timeout_cmd", {24'd0, cmd_o}, 32'h2C);

    // Default-width frame restricted to the last two rows.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    send_byte(0, 8'h2B);
    send_byte(1, 8'h00);
    send_byte(1, 8'hEE);
    send_byte(1, 8'h00);
    send_byte(1, 8'hEF);
    send_byte(0, 8'h2C);
    tick(4);
    for (int i = 0; i < 480; i++) exp_q.push_back({8'(238 + i / 240), 8'(i % 240)});
    p0 = n_pix; f0 = n_fd;
    sb_en = 1'b1;
    for (int i = 0; i < 480; i++) begin
      d16 = 16'(i);
      send_byte(1, d16[15:8]);
      send_byte(1, d16[7:0]);
    end
    tick(6);
    chk("frame_pix_count", n_pix - p0, 480);
    chk("frame_done_count", n_fd - f0, 1);
    chk("frame_done_addr", {16'd0, fd_addr}, 32'hEFEF);
    chk("frame_last_addr", {16'd0, pix_addr_o}, 32'hEFEF);
    chk("frame_last_data", {16'd0, pix_data_o}, 32'h01DF);
    chk("frame_queue_empty", exp_q.size(), 0);
    sb_en = 1'b0;
    send_byte(1, 8'hBE);
    send_byte(1, 8'hEF);
    tick(6);
    chk("frame_next_addr", {16'd0, pix_addr_o}, 32'hEE00);
    chk("frame_next_data", {16'd0, pix_data_o}, 32'hBEEF);
    chk("frame_done_once", n_fd - f0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic d16_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

endmodule
